// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-master RAM port arbiter.
package mem_arb_pkg;

    localparam int PORT_IBUS = 0;
    localparam int PORT_DBUS = 1;
    localparam int GNT_W     = 2;

    typedef enum logic {
        LAST_IBUS = 1'b0,
        LAST_DBUS = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Pure grant picker for the RAM port arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention;
// without it the data port has fixed priority over the instruction port.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic [GNT_W-1:0] i_elig,
    input  port_e            i_last,
    output logic [GNT_W-1:0] o_gnt,
    output logic             o_gnt_vld
);

    // Pick one eligible port; contention is resolved by the build-time policy
    always_comb begin
        o_gnt = '0;
        if (i_elig[PORT_DBUS] && i_elig[PORT_IBUS]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (i_last == LAST_DBUS) begin
                o_gnt[PORT_IBUS] = 1'b1;
            end else begin
                o_gnt[PORT_DBUS] = 1'b1;
            end
`else
            o_gnt[PORT_DBUS] = 1'b1;
`endif
        end else begin
            o_gnt = i_elig;
        end
    end

    assign o_gnt_vld = |i_elig;

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at the last-granted port.
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master front end for single_port_ram: instruction fetch (read-only)
// and data (read/write, byte enables). Absorbs the RAM's one-cycle read
// latency so each master sees a plain req/ack handshake.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ibus_req,
    input  logic [ADDR_WIDTH-1:0]   ibus_addr,
    output logic                    ibus_ack,
    output logic [DATA_WIDTH-1:0]   ibus_rdata,
    input  logic                    dbus_req,
    input  logic [ADDR_WIDTH-1:0]   dbus_addr,
    input  logic [DATA_WIDTH/8-1:0] dbus_we,
    input  logic [DATA_WIDTH-1:0]   dbus_wdata,
    output logic                    dbus_ack,
    output logic [DATA_WIDTH-1:0]   dbus_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    output logic [DATA_WIDTH/8-1:0] mem_write_en,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    logic                  r_infl_i;
    logic                  r_infl_d;
    port_e                 r_last;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;

    logic [GNT_W-1:0]      w_elig;
    logic [GNT_W-1:0]      w_gnt;
    logic                  w_gnt_vld;
    logic                  w_gnt_i;
    logic                  w_gnt_d;
    logic                  w_any_gnt;

    // A port in its ack cycle still presents the old request, so mask it.
    assign w_elig[PORT_IBUS] = ibus_req & ~r_infl_i;
    assign w_elig[PORT_DBUS] = dbus_req & ~r_infl_d;

    mem_arb_grant u_grant (
        .i_elig    (w_elig),
        .i_last    (r_last),
        .o_gnt     (w_gnt),
        .o_gnt_vld (w_gnt_vld)
    );

    // No grants while reset is held, so no write can be issued to the RAM.
    assign w_gnt_i   = w_gnt[PORT_IBUS] & ~reset;
    assign w_gnt_d   = w_gnt[PORT_DBUS] & ~reset;
    assign w_any_gnt = w_gnt_vld & ~reset;

    // Drive the RAM from the granted port; hold the last values when idle
    always_comb begin
        mem_addr     = r_addr;
        mem_din      = r_din;
        mem_write_en = '0;
        if (w_gnt_d) begin
            mem_addr     = dbus_addr;
            mem_din      = dbus_wdata;
            mem_write_en = dbus_we;
        end else if (w_gnt_i) begin
            mem_addr = ibus_addr;
        end
    end

    // In-flight flags become next cycle's acks; remember the last grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_infl_i <= 1'b0;
            r_infl_d <= 1'b0;
            r_last   <= LAST_IBUS;
            r_addr   <= '0;
            r_din    <= '0;
        end else begin
            r_infl_i <= w_gnt_i;
            r_infl_d <= w_gnt_d;
            if (w_any_gnt) begin
                r_addr <= mem_addr;
                r_din  <= mem_din;
                r_last <= w_gnt_d ? LAST_DBUS : LAST_IBUS;
            end
        end
    end

    assign ibus_ack   = r_infl_i;
    assign dbus_ack   = r_infl_d;
    assign ibus_rdata = mem_dout;
    assign dbus_rdata = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and a
// spec-level model of grants, acks and memory contents.
module tb_mem_port_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          ibus_req;
    logic [AW-1:0] ibus_addr;
    logic          ibus_ack;
    logic [DW-1:0] ibus_rdata;
    logic          dbus_req;
    logic [AW-1:0] dbus_addr;
    logic [BW-1:0] dbus_we;
    logic [DW-1:0] dbus_wdata;
    logic          dbus_ack;
    logic [DW-1:0] dbus_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [BW-1:0] mem_write_en;
    logic [DW-1:0] mem_dout;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_ack     (ibus_ack),
        .ibus_rdata   (ibus_rdata),
        .dbus_req     (dbus_req),
        .dbus_addr    (dbus_addr),
        .dbus_we      (dbus_we),
        .dbus_wdata   (dbus_wdata),
        .dbus_ack     (dbus_ack),
        .dbus_rdata   (dbus_rdata),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_write_en (mem_write_en),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM (read-first, one-cycle read latency)
    logic [DW-1:0] ram  [0:DEPTH-1];
    logic [DW-1:0] gold [0:DEPTH-1];

    always @(posedge clk) begin
        for (int b = 0; b < BW; b++)
            if (mem_write_en[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
        mem_dout <= ram[mem_addr];
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: who is owed an ack, what was last driven, memory image
    bit            m_ack_i, m_ack_d, m_rd_d, m_last_d;
    logic [AW-1:0] m_addr_i, m_addr_d, m_addr;
    logic [DW-1:0] m_din;

    always @(negedge clk) begin
        bit ei, ed, gi, gd;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed_din;
        logic [BW-1:0] ewe;
        if (reset) begin
            chk("rst_ibus_ack", DW'(ibus_ack), '0);
            chk("rst_dbus_ack", DW'(dbus_ack), '0);
            chk("rst_mem_we", DW'(mem_write_en), '0);
            chk("rst_mem_addr", DW'(mem_addr), '0);
            m_ack_i = 0; m_ack_d = 0; m_rd_d = 0; m_last_d = 0;
            m_addr = '0; m_din = '0;
        end else begin
            chk("ibus_ack", DW'(ibus_ack), DW'(m_ack_i));
            chk("dbus_ack", DW'(dbus_ack), DW'(m_ack_d));
            if (m_ack_i) chk("ibus_rdata", ibus_rdata, gold[m_addr_i]);
            if (m_ack_d && m_rd_d) chk("dbus_rdata", dbus_rdata, gold[m_addr_d]);
            ei = ibus_req && !m_ack_i;
            ed = dbus_req && !m_ack_d;
            if (ei && ed) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                gd = !m_last_d;
`else
                gd = 1;
`endif
                gi = !gd;
            end else begin
                gi = ei;
                gd = ed;
            end
            ea = m_addr; ed_din = m_din; ewe = '0;
            if (gd) begin
                ea = dbus_addr; ed_din = dbus_wdata; ewe = dbus_we;
            end else if (gi) begin
                ea = ibus_addr;
            end
            chk("mem_addr", DW'(mem_addr), DW'(ea));
            chk("mem_din", mem_din, ed_din);
            chk("mem_write_en", DW'(mem_write_en), DW'(ewe));
            if (gd) begin
                for (int b = 0; b < BW; b++)
                    if (dbus_we[b]) gold[dbus_addr][b*8 +: 8] = dbus_wdata[b*8 +: 8];
                m_addr_d = dbus_addr;
                m_rd_d   = (dbus_we == '0);
            end
            if (gi) m_addr_i = ibus_addr;
            if (gi || gd) begin
                m_addr = ea; m_din = ed_din; m_last_d = gd;
            end
            m_ack_i = gi;
            m_ack_d = gd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one data access, wait (bounded) for its ack, release next cycle
    task automatic dbus_access(input logic [AW-1:0] a, input logic [BW-1:0] we,
                               input logic [DW-1:0] wd, output int lat,
                               output logic [DW-1:0] rd);
        dbus_req = 1; dbus_addr = a; dbus_we = we; dbus_wdata = wd;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!dbus_ack && lat < 8);
        if (!dbus_ack) chk("dbus_ack_timeout", DW'(dbus_ack), DW'(1));
        rd = dbus_rdata;
        step();
        dbus_req = 0; dbus_we = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, na_i, na_d, both, cnt;
        logic [DW-1:0] rd;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = init_word(i);
            gold[i] = init_word(i);
        end
        reset = 1; ibus_req = 0; ibus_addr = '0; dbus_req = 0;
        dbus_addr = '0; dbus_we = '0; dbus_wdata = '0;
        repeat (2) step();
        chk("reset_ibus_ack", DW'(ibus_ack), '0);
        chk("reset_dbus_ack", DW'(dbus_ack), '0);
        chk("reset_mem_addr", DW'(mem_addr), '0);
        chk("reset_mem_din", mem_din, '0);
        chk("reset_mem_we", DW'(mem_write_en), '0);
        reset = 0;

        cnt = 0;
        repeat (3) begin
            step();
            if (ibus_ack || dbus_ack || (|mem_write_en)) cnt++;
        end
        chk("idle_activity", DW'(cnt), '0);

        // Simultaneous first requests: dbus first, ibus granted in dbus ack cycle
        ibus_req = 1; ibus_addr = 14'h020;
        dbus_req = 1; dbus_addr = 14'h030; dbus_we = '0;
        #1;
        chk("sim_first_grant_addr", DW'(mem_addr), DW'(14'h030));
        step();
        chk("sim_dbus_ack", DW'(dbus_ack), DW'(1));
        chk("sim_dbus_ibus_ack", DW'(ibus_ack), '0);
        chk("sim_dbus_rdata", dbus_rdata, 32'hC0DE_0030);
        chk("sim_second_grant_addr", DW'(mem_addr), DW'(14'h020));
        step();
        dbus_req = 0;
        chk("sim_ibus_ack", DW'(ibus_ack), DW'(1));
        chk("sim_ibus_rdata", ibus_rdata, 32'hC0DE_0020);
        chk("sim_ibus_dbus_ack", DW'(dbus_ack), '0);
        step();
        ibus_req = 0;
        step();

        // Lone partial write then read back
        dbus_access(14'h010, 4'b0011, 32'hA5A5_1234, lat, rd);
        chk("wr_latency", DW'(lat), DW'(1));
        dbus_access(14'h010, 4'b0000, '0, lat, rd);
        chk("rd_latency", DW'(lat), DW'(1));
        chk("rd_merged", rd, 32'hC0DE_1234);
        step();

        // Both ports streaming for 10 cycles
        ibus_req = 1; ibus_addr = 14'h040;
        dbus_req = 1; dbus_addr = 14'h050; dbus_we = '0;
        na_i = 0; na_d = 0; both = 0;
        repeat (10) begin
            step();
            if (ibus_ack) na_i++;
            if (dbus_ack) na_d++;
            if (ibus_ack && dbus_ack) both++;
        end
        chk("stream_ibus_acks", DW'(na_i), DW'(5));
        chk("stream_dbus_acks", DW'(na_d), DW'(5));
        chk("stream_double_ack", DW'(both), '0);
        ibus_req = 0; dbus_req = 0;
        repeat (2) step();

        // Lone ibus streaming
        ibus_req = 1; ibus_addr = 14'h060;
        na_i = 0; cnt = 0;
        repeat (8) begin
            if (|mem_write_en) cnt++;
            step();
            if (ibus_ack) na_i++;
        end
        chk("lone_ibus_acks", DW'(na_i), DW'(4));
        chk("lone_ibus_writes", DW'(cnt), '0);
        ibus_req = 0;
        repeat (2) step();

        // Reset pulse in the ack cycle of a dbus read
        dbus_req = 1; dbus_addr = 14'h070; dbus_we = '0;
        step();
        chk("pre_reset_ack", DW'(dbus_ack), DW'(1));
        reset = 1;
        #1;
        chk("reset_kills_ack", DW'(dbus_ack), '0);
        step();
        reset = 0; dbus_req = 0;
        cnt = 0;
        repeat (3) begin
            step();
            if (ibus_ack || dbus_ack) cnt++;
        end
        chk("post_reset_acks", DW'(cnt), '0);
        dbus_access(14'h070, 4'b0000, '0, lat, rd);
        chk("post_reset_latency", DW'(lat), DW'(1));
        chk("post_reset_rdata", rd, 32'hC0DE_0070);
        dbus_access(14'h070, 4'b1100, 32'h1122_3344, lat, rd);
        dbus_access(14'h070, 4'b0000, '0, lat, rd);
        chk("upper_lane_write", rd, 32'h1122_0070);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
